// File: rtl/digest_out_mux_pkg.sv
// Shared constants for the SHA-256 digest output path.
// Address tags match the input side's word/hash-variable space.
package digest_out_mux_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int ADDR_W    = 4;

    localparam logic [3:0] ADDR_W_SLOT = 4'd0;
    localparam logic [3:0] ADDR_H0     = 4'd1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/digest_out_mux_word_sel.sv
// Combinational word selector: picks digest word idx (H0 first)
// out of the flat captured buffer.
module digest_word_sel #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_WORDS*WORD_W-1:0] buf_i,
    input  logic [IDX_W-1:0]            idx_i,
    output logic [WORD_W-1:0]           word_o
);

    always_comb begin
        word_o = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (idx_i == IDX_W'(k)) begin
                word_o = buf_i[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/digest_out_mux.sv
// Captures a finished SHA-256 digest and streams it out one tagged
// word per valid/ready transfer, H0 (addr 1) through H7 (addr 8).
module digest_out_mux #(
    parameter int WORD_W    = digest_out_mux_pkg::WORD_W,
    parameter int NUM_WORDS = digest_out_mux_pkg::NUM_WORDS,
    parameter int ADDR_W    = digest_out_mux_pkg::ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WORDS*WORD_W-1:0] digest_in,
    input  logic                        digest_valid,
    output logic                        digest_ready,
    output logic [WORD_W-1:0]           out_data,
    output logic [ADDR_W-1:0]           out_addr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        done
);

    import digest_out_mux_pkg::ADDR_W_SLOT;
    import digest_out_mux_pkg::ADDR_H0;
    import digest_out_mux_pkg::ST_IDLE;
    import digest_out_mux_pkg::ST_SEND;

    localparam int               IDX_W    = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

    logic [0:0]                  state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_WORDS*WORD_W-1:0] digest_q, digest_d;
    logic                        done_q, done_d;
    logic [WORD_W-1:0]           sel_word;
    logic                        sending;
    logic                        capture;
    logic                        xfer;

    assign sending = (state_q == ST_SEND);
    assign capture = digest_valid & digest_ready;
    assign xfer    = out_valid & out_ready;

    digest_word_sel #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_word_sel (
        .buf_i  (digest_q),
        .idx_i  (idx_q),
        .word_o (sel_word)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        digest_d = digest_q;
        done_d   = 1'b0;
        if (capture) begin
            state_d  = ST_SEND;
            idx_d    = '0;
            digest_d = digest_in;
        end else if (xfer) begin
            // Final word: idx parks at 0 rather than wrapping through 7.
            if (idx_q == IDX_LAST) begin
                state_d = ST_IDLE;
                idx_d   = '0;
                done_d  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            digest_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            digest_q <= digest_d;
            done_q   <= done_d;
        end
    end

    assign digest_ready = (state_q == ST_IDLE);
    assign out_valid    = sending;
    assign out_last     = sending & (idx_q == IDX_LAST);
    assign out_data     = sending ? sel_word : '0;
    assign out_addr     = sending ? ADDR_W'(idx_q) + ADDR_W'(ADDR_H0)
                                  : ADDR_W'(ADDR_W_SLOT);
    assign done         = done_q;

endmodule

// File: tb/tb_digest_out_mux.sv
// Self-checking bench for digest_out_mux: table-driven digest streams
// with a word scoreboard, plus reset and back-to-back sequences.
module tb_digest_out_mux;

    logic         clk;
    logic         rst;
    logic [255:0] digest_in;
    logic         digest_valid;
    logic         digest_ready;
    logic [31:0]  out_data;
    logic [3:0]   out_addr;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         done;

    digest_out_mux dut (
        .clk          (clk),
        .rst          (rst),
        .digest_in    (digest_in),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  addr;
        logic        last;
    } exp_t;

    typedef struct {
        string        name;
        logic [255:0] dig;
        logic [31:0]  rdy;
        int           inj;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];
    int   n_chk;
    int   n_pass;

    localparam logic [255:0] ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic run_stream(input string nm, input logic [255:0] dig,
                              input logic [31:0] rdy, input int inj);
        exp_t        e;
        int          cyc;
        int          n;
        int          want;
        logic        hold;
        logic [31:0] pd;
        logic [3:0]  pa;
        want = 0;
        n    = 0;
        for (int c = 0; c < 32; c++) begin
            if (rdy[c] && n < 8) begin
                n++;
                if (n == 8) want = c + 1;
            end
        end
        chk({nm, ":cap_ready"}, 64'(digest_ready), 64'd1);
        digest_in    = dig;
        digest_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e.data = dig[255-32*k -: 32];
            e.addr = 4'(k + 1);
            e.last = (k == 7);
            sb.push_back(e);
        end
        @(negedge clk);
        digest_valid = 1'b0;
        cyc  = 0;
        n    = 0;
        hold = 1'b0;
        pd   = '0;
        pa   = '0;
        while (n < 8 && cyc < 200) begin
            out_ready = rdy[cyc % 32];
            if (cyc == inj) begin
                digest_in    = '1;
                digest_valid = 1'b1;
            end else begin
                digest_valid = 1'b0;
            end
            #1;
            chk({nm, ":valid"}, 64'(out_valid), 64'd1);
            chk({nm, ":busy"}, 64'(digest_ready), 64'd0);
            chk({nm, ":no_done"}, 64'(done), 64'd0);
            if (hold) begin
                chk({nm, ":hold_data"}, 64'(out_data), 64'(pd));
                chk({nm, ":hold_addr"}, 64'(out_addr), 64'(pa));
            end
            if (out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk({nm, ":data"}, 64'(out_data), 64'(e.data));
                chk({nm, ":addr"}, 64'(out_addr), 64'(e.addr));
                chk({nm, ":last"}, 64'(out_last), 64'(e.last));
                n++;
                hold = 1'b0;
            end else begin
                hold = 1'b1;
                pd   = out_data;
                pa   = out_addr;
            end
            @(negedge clk);
            cyc++;
        end
        digest_valid = 1'b0;
        out_ready    = 1'b0;
        chk({nm, ":xfers"}, 64'(n), 64'd8);
        chk({nm, ":cycles"}, 64'(cyc), 64'(want));
        chk({nm, ":done"}, 64'(done), 64'd1);
        chk({nm, ":ready_after"}, 64'(digest_ready), 64'd1);
        chk({nm, ":idle_valid"}, 64'(out_valid), 64'd0);
        chk({nm, ":idle_last"}, 64'(out_last), 64'd0);
        chk({nm, ":idle_data"}, 64'(out_data), 64'd0);
        chk({nm, ":idle_addr"}, 64'(out_addr), 64'd0);
    endtask

    initial begin
        exp_t e;
        n_chk        = 0;
        n_pass       = 0;
        rst          = 1'b1;
        digest_in    = '0;
        digest_valid = 1'b0;
        out_ready    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst:ready", 64'(digest_ready), 64'd1);
        chk("rst:valid", 64'(out_valid), 64'd0);
        chk("rst:data", 64'(out_data), 64'd0);
        chk("rst:addr", 64'(out_addr), 64'd0);
        chk("rst:last", 64'(out_last), 64'd0);
        chk("rst:done", 64'(done), 64'd0);
        @(negedge clk);

        vecs[0] = '{"abc", ABC, 32'hFFFF_FFFF, -1};
        vecs[1] = '{"bp", ABC, 32'h000A_AA05, -1};
        vecs[2] = '{"ign", ABC, 32'hFFFF_FFFF, 3};
        vecs[3] = '{"allf", {256{1'b1}}, 32'hFFFF_FFFF, -1};
        vecs[4] = '{"empty", EMPTY, 32'h6DB6_DB6D, 2};

        // Each stream starts in the previous stream's done cycle.
        for (int i = 0; i < 5; i++) begin
            run_stream(vecs[i].name, vecs[i].dig, vecs[i].rdy, vecs[i].inj);
        end
        @(negedge clk);
        chk("done_once", 64'(done), 64'd0);

        digest_in    = ABC;
        digest_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e.data = ABC[255-32*k -: 32];
            e.addr = 4'(k + 1);
            e.last = (k == 7);
            sb.push_back(e);
        end
        @(negedge clk);
        digest_valid = 1'b0;
        out_ready    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            e = sb.pop_front();
            chk("mid:valid", 64'(out_valid), 64'd1);
            chk("mid:data", 64'(out_data), 64'(e.data));
            chk("mid:addr", 64'(out_addr), 64'(e.addr));
            @(negedge clk);
        end
        rst          = 1'b1;
        digest_valid = 1'b1;
        digest_in    = '1;
        @(negedge clk);
        chk("mid:rst_valid", 64'(out_valid), 64'd0);
        chk("mid:rst_data", 64'(out_data), 64'd0);
        chk("mid:rst_addr", 64'(out_addr), 64'd0);
        chk("mid:rst_ready", 64'(digest_ready), 64'd1);
        chk("mid:rst_done", 64'(done), 64'd0);
        rst          = 1'b0;
        digest_valid = 1'b0;
        out_ready    = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid:no_capture", 64'(out_valid), 64'd0);
        chk("mid:no_done", 64'(done), 64'd0);
        run_stream("restart", ABC, 32'hFFFF_FFFF, -1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
